cc_background_scroller: RTL and testbench
=========================================

Name: cc_background_scroller

Overview:
- Downstream of the gameplay controller. Consumes its active-low background-load strobe and holds the scrolling road as NROWS rows of RDATAWIDTH lanes.
- On each strobe: shifts all rows one step toward the player, inserts new rival cars from an LFSR, keeps a passed-rows score and detects player/car collision.
- Feeds the display mux through a row-select readback port.

Parameters:
- RDATAWIDTH, 8, lanes per row; 8 is the only supported value because lane select is 3 bits.
- NROWS, 8, rows in the bank; row NROWS-1 is the player row.
- SEED, 8'hA5, LFSR reset value; a value of 0 is forced to 8'h01.
- GAP_ROWS, 2, number of empty rows inserted between consecutive car rows.

Ports:
- CC_BackScroll_CLOCK_50  in  1  system clock.
- CC_BackScroll_RESET_InHigh  in  1  synchronous, active-high reset.
- CC_BackScroll_load_InLow  in  1  active-low shift strobe from the gameplay controller.
- CC_BackScroll_enable_InHigh  in  1  game running.
- CC_BackScroll_player_InBUS  in  RDATAWIDTH  player lane occupancy, bottom row.
- CC_BackScroll_rowSel_InBUS  in  3  row index for readback.
- CC_BackScroll_row_OutBUS  out  RDATAWIDTH  selected row, registered.
- CC_BackScroll_crash_OutHigh  out  1  sticky collision flag.
- CC_BackScroll_shiftDone_OutHigh  out  1  one-cycle pulse per completed scroll.
- CC_BackScroll_score_OutBUS  out  8  car rows passed, saturating.

Behaviour:
- Reset: one clock, synchronous, active-high; it dominates all other inputs. The reset is a single clock and is synchronous, active-high; it applies to every register.
  - Values after reset: all rows 0, row_OutBUS 0, crash 0, shiftDone 0, score 0.
  - Internal state after reset: gap counter 0, LFSR=SEED, load-previous register 1, state IDLE.
  - Reset in any state, including mid-sequence, restores all of the above on the next edge.
- Edge detect:
  - load_prev is sampled every cycle.
  - A strobe is an edge where load_prev=1 and load_InLow=0.
  - Holding load low yields exactly one strobe.
  - Strobes arriving outside WAIT_LOAD are dropped.
- FSM states: IDLE, WAIT_LOAD, SHIFT, INSERT, CHECK, CRASHED.
  - IDLE -> WAIT_LOAD when enable=1.
  - WAIT_LOAD -> SHIFT on strobe.
  - WAIT_LOAD -> IDLE if enable=0 and no strobe. Rows and score are kept.
  - WAIT_LOAD: collision is checked every cycle, using |(row[NROWS-1] & player). If true, set crash=1 and go to CRASHED; this has priority over a strobe.
  - SHIFT: row[i]<=row[i-1] for i=NROWS-1..1, and row[0]<=0. If the old row[NROWS-1]!=0, score<=score+1, saturating at 255. Next state INSERT.
  - INSERT:
    - If gap==GAP_ROWS: row[0]<=one-hot(lfsr[2:0]) and gap<=0.
    - Otherwise gap<=gap+1.
    - The LFSR advances every INSERT.
    - Next state CHECK.
  - CHECK:
    - If collision: crash<=1 and go to CRASHED.
    - Otherwise: shiftDone<=1 for one cycle and go to WAIT_LOAD.
    - An enable drop during SHIFT, INSERT or CHECK does not abort the sequence.
  - CRASHED: terminal. Rows, score and LFSR are frozen, strobes are ignored, and shiftDone stays 0. Only reset exits this state.
- Latency: the strobe is sampled at edge E0; the shift happens at E1, the insert at E2, the check at E3; shiftDone is high during the cycle after E3.
- LFSR: 8-bit Fibonacci. Next value = {l[6:0], l[7]^l[5]^l[4]^l[3]}. The lane is taken from the value before the advance.
- Readback: row_OutBUS<=row[rowSel] every cycle, including CRASHED, with 1-cycle latency. rowSel>=NROWS returns 0.

Decomposition:
- Package cc_game_pkg holds:
  - state encodings;
  - RDATAWIDTH/NROWS defaults;
  - LFSR tap constants;
  - the score width (8) and saturation value.
- Sub-module cc_lfsr8 contains the LFSR. Ports: clk, sync reset, advance, seed param, value out.
- The row bank, edge detect and FSM stay in cc_background_scroller.

Test Plan:
- Car insertion: reset, enable=1, SEED=A5, GAP_ROWS=2, then 3 strobes. Rows stay 0 after strobes 1-2. LFSR runs A5->4A->95. After strobe 3, row[0]=8'h20 (lane 5) and shiftDone has pulsed 3 times.
- Scroll and score: continue for 7 more strobes with player=8'h01. The car is in row 7 after strobe 10 and there is no crash. Strobe 11 gives score=1 and row[7]=0.
- Crash: with the car in row 7 (8'h20), drive player=8'h20 in WAIT_LOAD. crash=1 within 1 cycle. Further strobes change nothing and shiftDone stays 0.
- Held strobe: load_InLow held low for 100 cycles gives exactly one shift and one shiftDone pulse, 4 edges after the first low sample.
- Reset mid-sequence: reset asserted while in INSERT. Next cycle all outputs are 0 and the LFSR is A5. No shiftDone pulse occurs.
- Saturation and readback: GAP_ROWS=0, player=0, 300 strobes gives score=255. rowSel=0 returns row[0] one cycle later.

Source files
------------

// File: rtl/cc_game_pkg.sv
// Shared types and constants for the car-game background scroller.
// Holds the FSM encoding, geometry defaults, LFSR taps and score limits.
package cc_game_pkg;

  localparam int RDATAWIDTH_DEF = 8;
  localparam int NROWS_DEF      = 8;

  localparam int               SCORE_W   = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

  // Feedback taps l[7]^l[5]^l[4]^l[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOAD,
    ST_SHIFT,
    ST_INSERT,
    ST_CHECK,
    ST_CRASHED
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cc_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when advance is high.
// A zero seed would lock the register, so it is replaced by 8'h01.
module cc_lfsr8
  import cc_game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] value
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/cc_background_scroller.sv
// Scrolling road bank: each load strobe shifts rows toward the player, drops
// in LFSR-chosen rival cars, counts passed car rows and latches a collision.
module cc_background_scroller
  import cc_game_pkg::*;
#(
  parameter int         RDATAWIDTH = RDATAWIDTH_DEF,
  parameter int         NROWS      = NROWS_DEF,
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         GAP_ROWS   = 2
) (
  input  logic                  CC_BackScroll_CLOCK_50,
  input  logic                  CC_BackScroll_RESET_InHigh,
  input  logic                  CC_BackScroll_load_InLow,
  input  logic                  CC_BackScroll_enable_InHigh,
  input  logic [RDATAWIDTH-1:0] CC_BackScroll_player_InBUS,
  input  logic [2:0]            CC_BackScroll_rowSel_InBUS,
  output logic [RDATAWIDTH-1:0] CC_BackScroll_row_OutBUS,
  output logic                  CC_BackScroll_crash_OutHigh,
  output logic                  CC_BackScroll_shiftDone_OutHigh,
  output logic [SCORE_W-1:0]    CC_BackScroll_score_OutBUS
);

  logic clk, rst;
  assign clk = CC_BackScroll_CLOCK_50;
  assign rst = CC_BackScroll_RESET_InHigh;

  state_e                                state_q, state_d;
  logic [NROWS-1:0][RDATAWIDTH-1:0]      rows_q, rows_d;
  logic [RDATAWIDTH-1:0]                 rd_q, rd_d;
  logic [7:0]                            gap_q, gap_d;
  logic [SCORE_W-1:0]                    score_q, score_d;
  logic                                  crash_q, crash_d;
  logic                                  done_q, done_d;
  logic                                  load_prev_q, load_prev_d;

  logic       lfsr_adv;
  logic [7:0] lfsr_val;
  logic       lfsr_unused;
  logic       strobe, collide;
  logic [RDATAWIDTH-1:0] car;

  cc_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  // Only the low three bits choose a lane; the rest is sequence state.
  assign lfsr_unused = ^lfsr_val[7:3];

  assign strobe  = load_prev_q & ~CC_BackScroll_load_InLow;
  assign collide = |(rows_q[NROWS-1] & CC_BackScroll_player_InBUS);
  assign car     = {{(RDATAWIDTH-1){1'b0}}, 1'b1} << lfsr_val[2:0];

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    gap_d       = gap_q;
    score_d     = score_q;
    crash_d     = crash_q;
    done_d      = 1'b0;
    lfsr_adv    = 1'b0;
    load_prev_d = CC_BackScroll_load_InLow;

    // Out-of-range selects fall through to zero.
    rd_d = '0;
    for (int i = 0; i < NROWS; i++)
      if (int'(CC_BackScroll_rowSel_InBUS) == i) rd_d = rows_q[i];

    unique case (state_q)
      ST_IDLE: if (CC_BackScroll_enable_InHigh) state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: begin
        if (collide) begin
          crash_d = 1'b1;
          state_d = ST_CRASHED;
        end else if (strobe) begin
          state_d = ST_SHIFT;
        end else if (!CC_BackScroll_enable_InHigh) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rows_q[NROWS-1] != '0 && score_q != SCORE_MAX) score_d = score_q + 1'b1;
        for (int i = NROWS-1; i > 0; i--) rows_d[i] = rows_q[i-1];
        rows_d[0] = '0;
        state_d   = ST_INSERT;
      end
      ST_INSERT: begin
        lfsr_adv = 1'b1;
        if (gap_q == 8'(GAP_ROWS)) begin
          rows_d[0] = car;
          gap_d     = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (collide) begin
          crash_d = 1'b1;
          state_d = ST_CRASHED;
        end else begin
          done_d  = 1'b1;
          state_d = ST_WAIT_LOAD;
        end
      end
      ST_CRASHED: state_d = ST_CRASHED;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      rd_q        <= '0;
      gap_q       <= '0;
      score_q     <= '0;
      crash_q     <= 1'b0;
      done_q      <= 1'b0;
      load_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      rd_q        <= rd_d;
      gap_q       <= gap_d;
      score_q     <= score_d;
      crash_q     <= crash_d;
      done_q      <= done_d;
      load_prev_q <= load_prev_d;
    end
  end

  assign CC_BackScroll_row_OutBUS        = rd_q;
  assign CC_BackScroll_crash_OutHigh     = crash_q;
  assign CC_BackScroll_shiftDone_OutHigh = done_q;
  assign CC_BackScroll_score_OutBUS      = score_q;

endmodule

// File: tb/tb_cc_background_scroller.sv
// Randomized bench for the background scroller against a row-level road model.
// Instance 0 uses GAP_ROWS=2, instance 1 uses GAP_ROWS=0 for score saturation.
module tb_cc_background_scroller;

  logic       clk;
  logic       rst   [2];
  logic       ld    [2];
  logic       en    [2];
  logic [7:0] pl    [2];
  logic [2:0] rs    [2];
  logic [7:0] row_o [2];
  logic       crash_o [2];
  logic       done_o  [2];
  logic [7:0] score_o [2];

  int n_vec = 0;
  int n_err = 0;

  // Road model: whole rows, score, crash flag, lane generator and gap count.
  logic [7:0] m_rows  [2][8];
  logic [7:0] m_score [2];
  logic       m_crash [2];
  logic [7:0] m_lfsr  [2];
  int         m_gap   [2];
  int         gapcfg  [2] = '{2, 0};

  cc_background_scroller #(.SEED(8'hA5), .GAP_ROWS(2)) u_dut (
    .CC_BackScroll_CLOCK_50          (clk),
    .CC_BackScroll_RESET_InHigh      (rst[0]),
    .CC_BackScroll_load_InLow        (ld[0]),
    .CC_BackScroll_enable_InHigh     (en[0]),
    .CC_BackScroll_player_InBUS      (pl[0]),
    .CC_BackScroll_rowSel_InBUS      (rs[0]),
    .CC_BackScroll_row_OutBUS        (row_o[0]),
    .CC_BackScroll_crash_OutHigh     (crash_o[0]),
    .CC_BackScroll_shiftDone_OutHigh (done_o[0]),
    .CC_BackScroll_score_OutBUS      (score_o[0])
  );

  cc_background_scroller #(.SEED(8'hA5), .GAP_ROWS(0)) u_dut_g0 (
    .CC_BackScroll_CLOCK_50          (clk),
    .CC_BackScroll_RESET_InHigh      (rst[1]),
    .CC_BackScroll_load_InLow        (ld[1]),
    .CC_BackScroll_enable_InHigh     (en[1]),
    .CC_BackScroll_player_InBUS      (pl[1]),
    .CC_BackScroll_rowSel_InBUS      (rs[1]),
    .CC_BackScroll_row_OutBUS        (row_o[1]),
    .CC_BackScroll_crash_OutHigh     (crash_o[1]),
    .CC_BackScroll_shiftDone_OutHigh (done_o[1]),
    .CC_BackScroll_score_OutBUS      (score_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset(input int i);
    for (int r = 0; r < 8; r++) m_rows[i][r] = 8'h00;
    m_score[i] = 8'h00;
    m_crash[i] = 1'b0;
    m_lfsr[i]  = 8'hA5;
    m_gap[i]   = 0;
  endtask

  // One scroll of the road: pass bottom row, move down, maybe drop a car.
  task automatic m_scroll(input int i);
    if (m_rows[i][7] != 8'h00 && m_score[i] != 8'd255) m_score[i] = m_score[i] + 8'd1;
    for (int r = 7; r > 0; r--) m_rows[i][r] = m_rows[i][r-1];
    m_rows[i][0] = 8'h00;
    if (m_gap[i] == gapcfg[i]) begin
      m_rows[i][0] = 8'd1 << m_lfsr[i][2:0];
      m_gap[i]     = 0;
    end else begin
      m_gap[i] = m_gap[i] + 1;
    end
    m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
  endtask

  task automatic read_row(input int i, input int r, output logic [7:0] v);
    rs[i] = 3'(r);
    @(negedge clk);
    v = row_o[i];
  endtask

  task automatic check_rows(input int i);
    logic [7:0] v;
    for (int r = 0; r < 8; r++) begin
      read_row(i, r, v);
      chk($sformatf("row%0d_i%0d", r, i), v, m_rows[i][r]);
    end
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
    m_reset(i);
    chk("rst_row",   row_o[i],   8'h00);
    chk("rst_crash", crash_o[i], 1'b0);
    chk("rst_done",  done_o[i],  1'b0);
    chk("rst_score", score_o[i], 8'h00);
    @(negedge clk);
  endtask

  task automatic set_player(input int i, input logic [7:0] p);
    pl[i] = p;
    @(negedge clk);
    if (!m_crash[i] && (m_rows[i][7] & p) != 8'h00) m_crash[i] = 1'b1;
    chk("crash_wait", crash_o[i], m_crash[i]);
  endtask

  task automatic strobe(input int i, input int hold, input bit drop_en, input bit full);
    int n, first;
    bit was_crashed;
    n = 0; first = -1; was_crashed = m_crash[i];
    ld[i] = 1'b0;
    for (int c = 1; c <= hold + 6; c++) begin
      @(negedge clk);
      if (c == hold) ld[i] = 1'b1;
      if (drop_en && c == 1) en[i] = 1'b0;
      if (done_o[i]) begin
        n++;
        if (first < 0) first = c;
      end
    end
    if (drop_en) begin
      en[i] = 1'b1;
      @(negedge clk);
    end
    if (!was_crashed) begin
      m_scroll(i);
      if ((m_rows[i][7] & pl[i]) != 8'h00) m_crash[i] = 1'b1;
    end
    chk("done_cnt", n, (was_crashed || m_crash[i]) ? 0 : 1);
    if (!m_crash[i]) chk("done_lat", first, 4);
    chk("crash", crash_o[i], m_crash[i]);
    chk("score", score_o[i], m_score[i]);
    if (full) check_rows(i);
  endtask

  // A strobe while the game is stopped must be ignored entirely.
  task automatic idle_drop(input int i);
    int n;
    n = 0;
    en[i] = 1'b0;
    repeat (3) @(negedge clk);
    ld[i] = 1'b0;
    @(negedge clk);
    ld[i] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done_o[i]) n++;
    end
    chk("idle_done", n, 0);
    en[i] = 1'b1;
    @(negedge clk);
    chk("idle_score", score_o[i], m_score[i]);
    check_rows(i);
  endtask

  initial begin
    logic [7:0] v, p;
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ld[i] = 1'b1; en[i] = 1'b1; pl[i] = 8'h00; rs[i] = 3'd0;
    end
    repeat (2) @(negedge clk);
    do_reset(0);
    do_reset(1);

    // Car insertion: first car appears on the third strobe in lane 5.
    for (int k = 0; k < 3; k++) strobe(0, 1, 0, 1);
    read_row(0, 0, v);
    chk("first_car", v, 8'h20);

    // Scroll the car down to the player row without hitting lane 0.
    set_player(0, 8'h01);
    for (int k = 0; k < 7; k++) strobe(0, 1, 0, 1);
    read_row(0, 7, v);
    chk("car_row7", v, 8'h20);
    chk("no_crash", crash_o[0], 1'b0);
    strobe(0, 1, 0, 1);
    chk("score_1", score_o[0], 8'd1);
    read_row(0, 7, v);
    chk("row7_clear", v, 8'h00);

    idle_drop(0);
    strobe(0, 2, 1, 1);

    // Crash: wait for a car in the player row, then steer into it.
    set_player(0, 8'h00);
    n = 0;
    while (m_rows[0][7] == 8'h00 && n < 20) begin
      strobe(0, 1, 0, 0);
      n++;
    end
    chk("car_found", (m_rows[0][7] != 8'h00), 1'b1);
    set_player(0, m_rows[0][7]);
    chk("crash_hit", crash_o[0], 1'b1);
    for (int k = 0; k < 3; k++) strobe(0, 1, 0, 1);
    do_reset(0);
    set_player(0, 8'h00);

    // Held strobe produces one scroll only.
    strobe(0, 100, 0, 1);

    // Reset during INSERT: no pulse, and the lane sequence restarts from seed.
    ld[0] = 1'b0;
    @(negedge clk);
    ld[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    m_reset(0);
    chk("mid_row",   row_o[0],   8'h00);
    chk("mid_crash", crash_o[0], 1'b0);
    chk("mid_score", score_o[0], 8'h00);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o[0]) n++;
    end
    chk("mid_done", n, 0);
    for (int k = 0; k < 3; k++) strobe(0, 1, 0, 0);
    read_row(0, 0, v);
    chk("seed_lane", v, 8'h20);

    // Random mix of strobes, player moves, pauses and recoveries.
    for (int k = 0; k < 60; k++) begin
      case ($urandom % 8)
        0: begin
          p = 8'($urandom);
          if (($urandom % 4) != 0) p = p & ~m_rows[0][7];
          set_player(0, p);
        end
        1: idle_drop(0);
        default: strobe(0, 1 + int'($urandom % 3), ($urandom % 5) == 0, 1);
      endcase
      if (m_crash[0] && ($urandom % 3) == 0) do_reset(0);
    end

    // Saturation on the gap-free instance.
    for (int k = 0; k < 300; k++) strobe(1, 1, 0, 0);
    chk("score_sat", score_o[1], 8'd255);
    read_row(1, 0, v);
    chk("rb_row0", v, m_rows[1][0]);
    read_row(1, 7, v);
    chk("rb_row7", v, m_rows[1][7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
